spi_slave_rx: RTL and testbench



---
 rtl/spi_slave_rx.sv | 173 +++++++++++++++++
 tb/tb_spi_slave_rx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx.sv
// SPI receive endpoint: synchronizes an external SCLK/data pair into the i_clock
// domain, deserializes DATA_WIDTH-bit words sampled on SCLK rising edges, and
// presents them through a valid/ready holding register with overrun and
// inter-bit timeout reporting.
// Optional build macro: SPI_RX_MSB_FIRST_EN (defined -> MSB-first word assembly,
// undefined -> LSB-first).
module spi_slave_rx #(
  parameter int DATA_WIDTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_sclk,
  input  logic                  i_msgBit,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_overrun,
  output logic                  o_timeout,
  output logic                  o_busy
);

  localparam int CNT_W  = $clog2(DATA_WIDTH);
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [TCNT_W-1:0] LAST_TICK = TCNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Synchronizer chains and edge detection
  logic [SYNC_STAGES-1:0] sclk_sync_reg;
  logic [SYNC_STAGES-1:0] data_sync_reg;
  logic                   prev_sclk_reg;
  logic                   sclk_s;
  logic                   data_s;
  logic                   sclk_rise;

  // Deserializer state
  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       bit_cnt_reg, bit_cnt_next;
  logic [TCNT_W-1:0]      tcnt_reg, tcnt_next;
  logic [DATA_WIDTH-1:0]  shift_reg, shift_next;
  logic [DATA_WIDTH-1:0]  shift_in;
  logic                   done_reg, done_next;
  logic                   timeout_reg, timeout_next;

  // Output holding register
  logic [DATA_WIDTH-1:0]  data_reg;
  logic                   valid_reg;
  logic                   overrun_reg;

  assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
  assign data_s    = data_sync_reg[SYNC_STAGES-1];
  assign sclk_rise = sclk_s && !prev_sclk_reg;

`ifdef SPI_RX_MSB_FIRST_EN
  // First received bit ends up in the MSB after a full word
  assign shift_in = {shift_reg[DATA_WIDTH-2:0], data_s};
`else
  // First received bit ends up in bit 0 after a full word
  assign shift_in = {data_s, shift_reg[DATA_WIDTH-1:1]};
`endif

  // Synchronize SCLK and data with equal delay; SCLK side resets high so a
  // clock held high through reset never looks like a fresh rising edge
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sclk_sync_reg <= '1;
      data_sync_reg <= '0;
      prev_sclk_reg <= 1'b1;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], i_sclk};
      data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], i_msgBit};
      prev_sclk_reg <= sclk_s;
    end
  end

  // Deserializer state register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      tcnt_reg    <= '0;
      shift_reg   <= '0;
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      tcnt_reg    <= tcnt_next;
      shift_reg   <= shift_next;
      done_reg    <= done_next;
      timeout_reg <= timeout_next;
    end
  end

  // Next-state logic: capture on SCLK rising edges, count idle cycles mid-word
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    tcnt_next    = tcnt_reg;
    shift_next   = shift_reg;
    done_next    = 1'b0;
    timeout_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sclk_rise) begin
          shift_next   = shift_in;
          bit_cnt_next = CNT_W'(1);
          tcnt_next    = '0;
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          shift_next = shift_in;
          tcnt_next  = '0;
          if (bit_cnt_reg == LAST_BIT) begin
            bit_cnt_next = '0;
            done_next    = 1'b1;
            state_next   = IDLE;
          end else begin
            bit_cnt_next = bit_cnt_reg + CNT_W'(1);
          end
        end else if (tcnt_reg == LAST_TICK) begin
          // Master stalled mid-word: drop the partial word and realign
          tcnt_next    = '0;
          bit_cnt_next = '0;
          timeout_next = 1'b1;
          state_next   = IDLE;
        end else begin
          tcnt_next = tcnt_reg + TCNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Holding register: a completed word loads unless an unaccepted word is
  // still held, in which case the new word is dropped and overrun flagged
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      overrun_reg <= 1'b0;
      if (done_reg) begin
        if (!valid_reg || i_ready) begin
          data_reg  <= shift_reg;
          valid_reg <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (valid_reg && i_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign o_data    = data_reg;
  assign o_valid   = valid_reg;
  assign o_overrun = overrun_reg;
  assign o_timeout = timeout_reg;
  assign o_busy    = (state_reg == SHIFT);

endmodule

// File: tb/tb_spi_slave_rx.sv
// Testbench for spi_slave_rx: directed scenarios followed by randomized words
// checked against a word-level reference model of the receive/handshake rules.
module tb_spi_slave_rx;

  localparam int DW = 8;
  localparam int SS = 2;
  localparam int TO = 64;

  logic          i_clock = 1'b0;
  logic          i_reset;
  logic          i_sclk;
  logic          i_msgBit;
  logic          i_ready;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          o_overrun;
  logic          o_timeout;
  logic          o_busy;

  int checks   = 0;
  int failures = 0;

  // Event bookkeeping filled by the output monitor
  int   cyc      = 0;
  int   ovr_cnt  = 0;
  int   to_cnt   = 0;
  int   to_cyc   = 0;
  int   load_cyc = 0;
  logic valid_d  = 1'b0;
  int   last_high_cyc = 0;

  spi_slave_rx #(
    .DATA_WIDTH     (DW),
    .SYNC_STAGES    (SS),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_sclk    (i_sclk),
    .i_msgBit  (i_msgBit),
    .i_ready   (i_ready),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_overrun (o_overrun),
    .o_timeout (o_timeout),
    .o_busy    (o_busy)
  );

  always #5 i_clock = ~i_clock;

  // Count clock edges and record output events just after each edge
  always begin
    @(posedge i_clock);
    #1;
    cyc++;
    if (o_overrun) ovr_cnt++;
    if (o_timeout) begin
      to_cnt++;
      to_cyc = cyc;
    end
    if (o_valid && !valid_d) load_cyc = cyc;
    valid_d = o_valid;
  end

  // Safety net so the run always ends
  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected word for a stream whose element 0 is sent first
  function automatic logic [DW-1:0] ref_word(input logic [31:0] bits, input int n);
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < n; i++) begin
`ifdef SPI_RX_MSB_FIRST_EN
      w[DW-1-i] = bits[i];
`else
      w[i] = bits[i];
`endif
    end
    return w;
  endfunction

  // Send n bits (bits[0] first) with a 4-clock SCLK; returns once the word
  // would have reached the holding register. SCLK is left high.
  task automatic send_bits(input logic [31:0] bits, input int n, input bit ready_at_done);
    for (int i = 0; i < n; i++) begin
      @(negedge i_clock);
      i_sclk   = 1'b0;
      i_msgBit = bits[i];
      @(negedge i_clock);
      @(negedge i_clock);
      i_sclk = 1'b1;
      if (i < n - 1) @(negedge i_clock);
    end
    last_high_cyc = cyc;
    for (int k = 0; k < SS + 2; k++) begin
      @(negedge i_clock);
      if (ready_at_done && (cyc == last_high_cyc + SS + 1)) i_ready = 1'b1;
    end
  endtask

  initial begin
    int            exp_ovr;
    int            base;
    logic          r;
    logic [31:0]   w;
    logic [DW-1:0] model_data;
    logic          model_valid;

    exp_ovr  = 0;
    i_reset  = 1'b1;
    i_sclk   = 1'b0;
    i_msgBit = 1'b0;
    i_ready  = 1'b1;
    repeat (3) @(negedge i_clock);

    // Reset state
    chk("reset_valid",   32'(o_valid),   32'(0));
    chk("reset_data",    32'(o_data),    32'(0));
    chk("reset_busy",    32'(o_busy),    32'(0));
    chk("reset_overrun", 32'(o_overrun), 32'(0));
    chk("reset_timeout", 32'(o_timeout), 32'(0));
    i_reset = 1'b0;
    repeat (2) @(negedge i_clock);

    // 1: single word with ready high
    send_bits(32'hA5, DW, 1'b0);
    $display("tx 0xA5 ready=1 -> data=0x%0h valid=%0b", o_data, o_valid);
    chk("t1_valid",   32'(o_valid), 32'(1));
    chk("t1_data",    32'(o_data),  32'hA5);
    chk("t1_latency", 32'(load_cyc - last_high_cyc), 32'(SS + 2));
    chk("t1_busy",    32'(o_busy),  32'(0));
    chk("t1_overrun", 32'(ovr_cnt), 32'(exp_ovr));
    @(negedge i_clock);
    chk("t1_pulse",   32'(o_valid), 32'(0));
    i_sclk = 1'b0;
    repeat (3) @(negedge i_clock);

    // 2: backpressure, second word overruns
    i_ready = 1'b0;
    send_bits(32'h3C, DW, 1'b0);
    $display("tx 0x3C ready=0 -> data=0x%0h valid=%0b", o_data, o_valid);
    chk("t2_first_data",  32'(o_data),  32'h3C);
    chk("t2_first_valid", 32'(o_valid), 32'(1));
    send_bits(32'hC3, DW, 1'b0);
    exp_ovr++;
    $display("tx 0xC3 ready=0 -> data=0x%0h overruns=%0d", o_data, ovr_cnt);
    chk("t2_overrun",    32'(ovr_cnt), 32'(exp_ovr));
    chk("t2_keep_data",  32'(o_data),  32'h3C);
    chk("t2_keep_valid", 32'(o_valid), 32'(1));
    repeat (3) @(negedge i_clock);
    chk("t2_overrun_once", 32'(ovr_cnt), 32'(exp_ovr));
    i_ready = 1'b1;
    @(negedge i_clock);
    chk("t2_drain_valid", 32'(o_valid), 32'(0));
    chk("t2_drain_data",  32'(o_data),  32'h3C);
    i_sclk = 1'b0;
    repeat (3) @(negedge i_clock);

    // 3: ready asserted exactly in the completion cycle of the second word
    i_ready = 1'b0;
    send_bits(32'h3C, DW, 1'b0);
    chk("t3_first_data", 32'(o_data), 32'h3C);
    send_bits(32'hC3, DW, 1'b1);
    $display("tx 0xC3 ready@done -> data=0x%0h valid=%0b", o_data, o_valid);
    chk("t3_data",    32'(o_data),  32'hC3);
    chk("t3_valid",   32'(o_valid), 32'(1));
    chk("t3_overrun", 32'(ovr_cnt), 32'(exp_ovr));
    @(negedge i_clock);
    chk("t3_drain", 32'(o_valid), 32'(0));
    i_sclk = 1'b0;
    repeat (3) @(negedge i_clock);

    // 4: partial word times out, then a full word is received cleanly
    base = to_cnt;
    send_bits(32'h5, 3, 1'b0);
    chk("t4_busy_mid", 32'(o_busy), 32'(1));
    i_sclk = 1'b0;
    for (int k = 0; k < 4 * TO && to_cnt == base; k++) @(negedge i_clock);
    $display("tx 3 bits then stall -> timeouts=%0d", to_cnt - base);
    chk("t4_timeout_seen", 32'(to_cnt - base), 32'(1));
    chk("t4_timeout_when", 32'(to_cyc - last_high_cyc), 32'(SS + 1 + TO));
    chk("t4_timeout_pulse", 32'(o_timeout), 32'(1));
    chk("t4_busy_after", 32'(o_busy), 32'(0));
    @(negedge i_clock);
    chk("t4_timeout_end", 32'(o_timeout), 32'(0));
    send_bits(32'h81, DW, 1'b0);
    $display("tx 0x81 after timeout -> data=0x%0h", o_data);
    chk("t4_data",  32'(o_data),  32'h81);
    chk("t4_valid", 32'(o_valid), 32'(1));
    repeat (3) @(negedge i_clock);

    // 5: reset mid-word with SCLK held high
    send_bits(32'h1F, 5, 1'b0);
    i_reset = 1'b1;
    @(negedge i_clock);
    i_reset = 1'b0;
    chk("t5_rst_data",    32'(o_data),    32'(0));
    chk("t5_rst_valid",   32'(o_valid),   32'(0));
    chk("t5_rst_busy",    32'(o_busy),    32'(0));
    chk("t5_rst_overrun", 32'(o_overrun), 32'(0));
    chk("t5_rst_timeout", 32'(o_timeout), 32'(0));
    repeat (10) @(negedge i_clock);
    chk("t5_no_spurious", 32'(o_busy), 32'(0));
    send_bits(32'h5A, DW, 1'b0);
    $display("tx 0x5A after reset -> data=0x%0h", o_data);
    chk("t5_data", 32'(o_data), 32'h5A);
    chk("t5_overrun", 32'(ovr_cnt), 32'(exp_ovr));
    i_sclk = 1'b0;
    repeat (3) @(negedge i_clock);

    // 6: bit order with stream 1,0,0,0,0,0,0,0
    send_bits(32'h01, DW, 1'b0);
    $display("tx stream 1,0,0,0,0,0,0,0 -> data=0x%0h", o_data);
    chk("t6_order", 32'(o_data), 32'(ref_word(32'h01, DW)));
    i_sclk = 1'b0;
    repeat (3) @(negedge i_clock);

    // Randomized words with random backpressure against the word-level model
    model_data  = ref_word(32'h01, DW);
    model_valid = 1'b0;
    for (int t = 0; t < 16; t++) begin
      r = 1'($urandom_range(0, 1));
      w = $urandom;
      @(negedge i_clock);
      i_ready = r;
      @(negedge i_clock);
      if (r) model_valid = 1'b0;
      send_bits(w, DW, 1'b0);
      if (!model_valid || r) begin
        model_data  = ref_word(w, DW);
        model_valid = 1'b1;
      end else begin
        exp_ovr++;
      end
      @(negedge i_clock);
      @(negedge i_clock);
      if (r) model_valid = 1'b0;
      i_sclk = 1'b0;
      $display("rand %0d tx=0x%0h ready=%0b -> data=0x%0h valid=%0b overruns=%0d",
               t, w[DW-1:0], r, o_data, o_valid, ovr_cnt);
      chk("rand_data",    32'(o_data),  32'(model_data));
      chk("rand_valid",   32'(o_valid), 32'(model_valid));
      chk("rand_overrun", 32'(ovr_cnt), 32'(exp_ovr));
    end

    repeat (3) @(negedge i_clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
